ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard over the same two open-drain lines that the PS/2 scancode receiver listens on. It runs the full host-to-device sequence: clock inhibit, request-to-send, 8 data bits LSB first, odd parity, stop, and the device's ACK. It reports the outcome with a done pulse and an error code. It sits beside the receiver at top level; `tx_busy` tells the receiver to discard line activity during a transmission.

---
 rtl/ps2_pkg.sv | 45 ++++
 rtl/ps2_line_sync.sv | 46 ++++
 rtl/ps2_host_tx.sv | 215 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 state encoding, error codes and timing defaults
//
// Purpose: common types and constants for the PS/2 host transmitter and the
//          scancode receiver that sits beside it.
// Ports:   none (package).

package ps2_pkg;

  // Default timing at a 50 MHz system clock.
  localparam int DEF_INHIBIT_CYCLES = 6000;    // 120 us CLK inhibit
  localparam int DEF_RTS_CYCLES     = 50;      // 1 us request-to-send
  localparam int DEF_START_TIMEOUT  = 750000;  // 15 ms for first device edge
  localparam int DEF_XFER_TIMEOUT   = 100000;  // 2 ms for the whole frame

  // start bit is implicit (DAT held low); frame register holds d0..d7, parity, stop
  localparam int FRAME_BITS = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_WAIT_CLK,
    ST_SEND,
    ST_WAIT_ACK,
    ST_WAIT_IDLE,
    ST_ERR
  } ps2_tx_state_e;

  typedef enum logic [1:0] {
    TX_ERR_OK       = 2'b00,
    TX_ERR_NACK     = 2'b01,
    TX_ERR_START_TO = 2'b10,
    TX_ERR_XFER_TO  = 2'b11
  } ps2_tx_err_e;

  // Bits needed by a down-counter loaded with n-1; never narrower than 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - PS/2 pad synchronizer with CLK falling-edge detect
//
// Purpose: brings the raw PS2_CLK / PS2_DAT pad levels into the system clock
//          domain through two flops each and flags falling edges of the
//          synchronized CLK.
// Ports:
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset
//   clk_pad_i   raw PS2_CLK level
//   dat_pad_i   raw PS2_DAT level
//   clk_sync_o  synchronized CLK
//   dat_sync_o  synchronized DAT
//   clk_fall_o  one-cycle flag: synced CLK went 1 -> 0

module ps2_line_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clk_pad_i,
  input  logic dat_pad_i,
  output logic clk_sync_o,
  output logic dat_sync_o,
  output logic clk_fall_o
);

  logic [1:0] clk_sync_q;
  logic [1:0] dat_sync_q;
  logic       clk_prev_q;

  // Reset to the idle (pulled-up) level so leaving reset never looks like an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], clk_pad_i};
      dat_sync_q <= {dat_sync_q[0], dat_pad_i};
      clk_prev_q <= clk_sync_q[1];
    end
  end

  assign clk_sync_o = clk_sync_q[1];
  assign dat_sync_o = dat_sync_q[1];
  assign clk_fall_o = clk_prev_q & ~clk_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
//
// Purpose: sends one command byte to a PS/2 device: CLK inhibit, request to
//          send, 8 data bits LSB first, odd parity, stop, then checks the
//          device ACK. Reports completion with tx_done and a 2-bit tx_err.
// Ports:
//   CLOCK_50           system clock
//   Resetn             asynchronous active-low reset
//   cmd_data/valid     command byte and request; cmd_ready high only when idle
//   ps2_clk_in/dat_in  raw pad levels
//   ps2_clk_drive_low  1 = pull PS2_CLK low, 0 = release
//   ps2_dat_drive_low  1 = pull PS2_DAT low, 0 = release
//   tx_busy            high whenever a transaction is in progress
//   tx_done            one-cycle completion pulse
//   tx_err             00 ok, 01 NACK, 10 start timeout, 11 transfer timeout

module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int RTS_CYCLES     = DEF_RTS_CYCLES,
  parameter int START_TIMEOUT  = DEF_START_TIMEOUT,
  parameter int XFER_TIMEOUT   = DEF_XFER_TIMEOUT
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_dat_drive_low,
  output logic       tx_busy,
  output logic       tx_done,
  output logic [1:0] tx_err
);

  // Inhibit, RTS and the start wait are strictly sequential, so they share
  // one down-counter sized for the longest of the three.
  localparam int PW = cnt_width(max2(max2(INHIBIT_CYCLES, RTS_CYCLES), START_TIMEOUT));
  localparam int XW = cnt_width(XFER_TIMEOUT);

  localparam logic [PW-1:0] INH_LOAD   = PW'(INHIBIT_CYCLES - 1);
  localparam logic [PW-1:0] RTS_LOAD   = PW'(RTS_CYCLES - 1);
  localparam logic [PW-1:0] START_LOAD = PW'(START_TIMEOUT - 1);
  localparam logic [XW-1:0] XFER_LOAD  = XW'(XFER_TIMEOUT - 1);

  ps2_tx_state_e         state_q, state_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [3:0]            bitcnt_q, bitcnt_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic [XW-1:0]         xfer_q, xfer_d;
  ps2_tx_err_e           code_q, code_d;
  ps2_tx_err_e           err_q;

  logic        clk_s;
  logic        dat_s;
  logic        clk_fall;
  logic        done_c;
  ps2_tx_err_e done_code_c;

  ps2_line_sync u_sync (
    .clk_i      (CLOCK_50),
    .rst_ni     (Resetn),
    .clk_pad_i  (ps2_clk_in),
    .dat_pad_i  (ps2_dat_in),
    .clk_sync_o (clk_s),
    .dat_sync_o (dat_s),
    .clk_fall_o (clk_fall)
  );

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= ST_IDLE;
      frame_q  <= '1;
      bitcnt_q <= '0;
      phase_q  <= '0;
      xfer_q   <= '0;
      code_q   <= TX_ERR_OK;
      err_q    <= TX_ERR_OK;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      bitcnt_q <= bitcnt_d;
      phase_q  <= phase_d;
      xfer_q   <= xfer_d;
      code_q   <= code_d;
      if (done_c) err_q <= done_code_c;
    end
  end

  always_comb begin
    state_d           = state_q;
    frame_d           = frame_q;
    bitcnt_d          = bitcnt_q;
    phase_d           = phase_q;
    xfer_d            = xfer_q;
    code_d            = code_q;
    done_c            = 1'b0;
    done_code_c       = TX_ERR_OK;
    ps2_clk_drive_low = 1'b0;
    ps2_dat_drive_low = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          frame_d  = {1'b1, ~^cmd_data, cmd_data};
          bitcnt_d = '0;
          phase_d  = INH_LOAD;
          state_d  = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        ps2_clk_drive_low = 1'b1;
        if (phase_q == '0) begin
          phase_d = RTS_LOAD;
          state_d = ST_RTS;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end

      ST_RTS: begin
        ps2_clk_drive_low = 1'b1;
        ps2_dat_drive_low = 1'b1;
        if (phase_q == '0) begin
          phase_d = START_LOAD;
          state_d = ST_WAIT_CLK;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end

      ST_WAIT_CLK: begin
        // start bit: DAT stays low until the device's first falling edge
        ps2_dat_drive_low = 1'b1;
        if (clk_fall) begin
          bitcnt_d = 4'd1;
          xfer_d   = XFER_LOAD;
          state_d  = ST_SEND;
        end else if (phase_q == '0) begin
          code_d  = TX_ERR_START_TO;
          state_d = ST_ERR;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end

      ST_SEND: begin
        // frame_q[0] is the bit currently on the line; shift in ones so the
        // line is released once the stop bit has gone out.
        ps2_dat_drive_low = ~frame_q[0];
        if (xfer_q == '0) begin
          code_d  = TX_ERR_XFER_TO;
          state_d = ST_ERR;
        end else begin
          xfer_d = xfer_q - 1'b1;
          if (clk_fall) begin
            frame_d  = {1'b1, frame_q[FRAME_BITS-1:1]};
            bitcnt_d = bitcnt_q + 1'b1;
            // the 10th edge puts the stop bit out; the next edge is the ACK
            if (bitcnt_q == 4'd9) state_d = ST_WAIT_ACK;
          end
        end
      end

      ST_WAIT_ACK: begin
        if (xfer_q == '0) begin
          code_d  = TX_ERR_XFER_TO;
          state_d = ST_ERR;
        end else begin
          xfer_d = xfer_q - 1'b1;
          if (clk_fall) begin
            if (!dat_s) begin
              state_d = ST_WAIT_IDLE;
            end else begin
              code_d  = TX_ERR_NACK;
              state_d = ST_ERR;
            end
          end
        end
      end

      ST_WAIT_IDLE: begin
        if (clk_s && dat_s) begin
          done_c      = 1'b1;
          done_code_c = TX_ERR_OK;
          state_d     = ST_IDLE;
        end else if (xfer_q == '0) begin
          code_d  = TX_ERR_XFER_TO;
          state_d = ST_ERR;
        end else begin
          xfer_d = xfer_q - 1'b1;
        end
      end

      ST_ERR: begin
        done_c      = 1'b1;
        done_code_c = code_q;
        state_d     = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign tx_busy   = (state_q != ST_IDLE);
  assign tx_done   = done_c;
  // the code is visible together with the pulse, then held by err_q
  assign tx_err    = done_c ? done_code_c : err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model

module tb_ps2_host_tx;

  localparam int INH      = 60;
  localparam int RTS      = 10;
  localparam int START_TO = 3000;
  localparam int XFER_TO  = 2000;
  localparam int HALF     = 20;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       clk_drive_low;
  logic       dat_drive_low;
  logic       tx_busy;
  logic       tx_done;
  logic [1:0] tx_err;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       ps2_clk_pad;
  logic       ps2_dat_pad;

  // open-drain wired-AND of host and device
  assign ps2_clk_pad = ~(clk_drive_low | dev_clk_low);
  assign ps2_dat_pad = ~(dat_drive_low | dev_dat_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .RTS_CYCLES     (RTS),
    .START_TIMEOUT  (START_TO),
    .XFER_TIMEOUT   (XFER_TO)
  ) dut (
    .CLOCK_50          (clk),
    .Resetn            (resetn),
    .cmd_data          (cmd_data),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .ps2_clk_in        (ps2_clk_pad),
    .ps2_dat_in        (ps2_dat_pad),
    .ps2_clk_drive_low (clk_drive_low),
    .ps2_dat_drive_low (dat_drive_low),
    .tx_busy           (tx_busy),
    .tx_done           (tx_done),
    .tx_err            (tx_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // cycle counter and done monitor
  int         cyc = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  logic [1:0] done_err = 2'b00;
  logic       done_lines = 1'b0;
  logic       done_busy = 1'b0;
  logic       done_prev = 1'b0;
  logic       post_busy = 1'b0;
  logic       post_done = 1'b0;
  logic       post_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done_prev) begin
      post_busy  <= tx_busy;
      post_done  <= tx_done;
      post_ready <= cmd_ready;
    end
    if (tx_done) begin
      done_cnt   <= done_cnt + 1;
      done_cyc   <= cyc;
      done_err   <= tx_err;
      done_lines <= clk_drive_low | dat_drive_low;
      done_busy  <= tx_busy;
    end
    done_prev <= tx_done;
  end

  int          acc_cyc, clk_low_cnt, dat_first, wclk_cyc, first_fall_cyc, n_samp;
  logic        wclk_dat;
  logic [10:0] samp;

  // Handshake one command and measure the inhibit / RTS phase up to WAIT_CLK.
  // poke >= 0 raises cmd_valid again at that inhibit cycle with another byte.
  task automatic issue(input logic [7:0] b, input int poke);
    int g;
    @(negedge clk);
    cmd_data  = b;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid   = 1'b0;
    acc_cyc     = cyc;
    clk_low_cnt = 0;
    dat_first   = -1;
    g           = 0;
    while (clk_drive_low === 1'b1 && g < 20000) begin
      clk_low_cnt++;
      if (dat_drive_low === 1'b1 && dat_first < 0) dat_first = cyc - acc_cyc;
      cmd_valid = (g == poke);
      if (g == poke) cmd_data = 8'h99;
      @(negedge clk);
      g++;
    end
    cmd_valid = 1'b0;
    wclk_cyc  = cyc;
    wclk_dat  = dat_drive_low;
  endtask

  // Device: generates `edges` clock pulses, samples DAT on each rising edge
  // for the first ten, pulls DAT low across the 11th pulse when ack is set.
  task automatic device(input int edges, input bit ack);
    n_samp         = 0;
    samp           = '0;
    first_fall_cyc = -1;
    for (int k = 1; k <= edges; k++) begin
      repeat (HALF) @(negedge clk);
      if (k == 11 && ack) dev_dat_low = 1'b1;
      if (k == 1) first_fall_cyc = cyc;
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      if (k <= 10) begin
        samp[n_samp] = ps2_dat_pad;
        n_samp++;
      end
    end
    repeat (HALF) @(negedge clk);
    dev_dat_low = 1'b0;
  endtask

  task automatic wait_done(input int base, input int bound, output bit ok);
    int g;
    g = 0;
    while (done_cnt == base && g < bound) begin
      @(negedge clk);
      #1;
      g++;
    end
    ok = (done_cnt != base);
  endtask

  task automatic run_vec(input logic [7:0] b, input int edges, input bit ack,
                         input logic [1:0] exp_err, input logic exp_par, input int poke);
    int base;
    bit ok;
    base = done_cnt;
    check("ready_before_cmd", cmd_ready, 1);
    issue(b, poke);
    check("clk_low_cycles", clk_low_cnt, INH + RTS);
    check("dat_low_first_cycle", dat_first, INH);
    check("start_bit_held", wclk_dat, 1);
    device(edges, ack);
    wait_done(base, START_TO + XFER_TO, ok);
    check("done_seen", ok, 1);
    repeat (3) @(negedge clk);
    #1;
    check("done_count", done_cnt - base, 1);
    check("err_code", done_err, exp_err);
    check("lines_released_at_done", done_lines, 0);
    check("busy_during_done", done_busy, 1);
    check("done_one_cycle", post_done, 0);
    check("busy_after_done", post_busy, 0);
    check("ready_after_done", post_ready, 1);
    check("err_held", tx_err, exp_err);
    if (edges >= 10) begin
      check("sample_count", n_samp, 10);
      check("data_lsb_first", samp[7:0], b);
      check("parity_bit", samp[8], exp_par);
      check("stop_bit", samp[9], 1);
    end
    if (edges == 0)
      check("start_timeout_cycles", done_cyc - wclk_cyc, START_TO);
    else if (edges < 10)
      check_range("xfer_timeout_cycles", done_cyc - first_fall_cyc, XFER_TO, XFER_TO + 6);
  endtask

  typedef struct {
    logic [7:0] data;
    int         edges;
    bit         ack;
    logic [1:0] err;
    logic       par;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0] b;
    bit         ack;
    logic       par;
    int         base;
    int         relow;

    vecs[0] = '{data: 8'hED, edges: 11, ack: 1'b1, err: 2'b00, par: 1'b1};
    vecs[1] = '{data: 8'hF4, edges: 11, ack: 1'b1, err: 2'b00, par: 1'b0};
    vecs[2] = '{data: 8'hFF, edges: 11, ack: 1'b0, err: 2'b01, par: 1'b1};
    vecs[3] = '{data: 8'h5A, edges: 5,  ack: 1'b1, err: 2'b11, par: 1'b1};
    vecs[4] = '{data: 8'hA5, edges: 0,  ack: 1'b1, err: 2'b10, par: 1'b1};

    resetn    = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_err", tx_err, 2'b00);
    check("rst_clk_drive", clk_drive_low, 0);
    check("rst_dat_drive", dat_drive_low, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_ready", cmd_ready, 1);

    for (int i = 0; i < 5; i++)
      run_vec(vecs[i].data, vecs[i].edges, vecs[i].ack, vecs[i].err, vecs[i].par, -1);

    // randomized bytes and ACK/NACK against the parity/bit-order model
    for (int i = 0; i < 6; i++) begin
      b   = 8'($urandom);
      ack = ($urandom_range(0, 3) != 0);
      par = (($countones(b) % 2) == 0);
      run_vec(b, 11, ack, ack ? 2'b00 : 2'b01, par, -1);
    end

    // cmd_valid during INHIBIT must not disturb or queue anything
    run_vec(8'h3C, 11, 1'b1, 2'b00, 1'b1, 20);
    base  = done_cnt;
    relow = 0;
    for (int i = 0; i < 2 * (INH + RTS); i++) begin
      @(negedge clk);
      if (clk_drive_low === 1'b1) relow++;
    end
    #1;
    check("no_queued_cmd", relow, 0);
    check("no_extra_done", done_cnt - base, 0);

    // asynchronous reset in the middle of SEND (d3 of 0x00 holds DAT low)
    base = done_cnt;
    issue(8'h00, -1);
    device(4, 1'b1);
    @(negedge clk);
    check("pre_reset_busy", tx_busy, 1);
    check("pre_reset_dat_low", dat_drive_low, 1);
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_dat_release", dat_drive_low, 0);
    check("async_rst_clk_release", clk_drive_low, 0);
    check("async_rst_busy", tx_busy, 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("after_rst_ready", cmd_ready, 1);
    check("after_rst_no_done", done_cnt - base, 0);

    // block is usable again after the reset
    run_vec(8'hF4, 11, 1'b1, 2'b00, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
